captura_7seg_binario: RTL and testbench

Recovers hexadecimal values from a multiplexed, active-low 7-segment display bus (segment lines plus active-low digit anodes) and delivers the 4-digit value as a 16-bit word through a valid/ready handshake. Performs the inverse of the binary-to-7-segment decoding used on the display side. It sits between the display pins, or a probe of them, and any consumer that needs the shown value, such as a self-check or readback logic.

---
 rtl/captura_7seg_binario.sv | 220 ++++++++++++++++++++++
 tb/tb_captura_7seg_binario.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/captura_7seg_binario.sv
// Recovers a 4-digit hex value from a multiplexed active-low 7-segment bus and hands it out over valid/ready.
// Optional feature macro CAPTURA_BLANCO_EN: accept the all-off pattern as a blank digit and report it on o_Blanco.
module captura_7seg_binario #(
  parameter int ESTABLE = 4
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic [6:0]  i_Segmentos,
  input  logic [3:0]  i_Anodos,
  input  logic        i_Listo,
  output logic [15:0] o_Valor,
  output logic        o_Valido,
  output logic        o_Error,
  output logic [1:0]  o_Digito_err,
  output logic        o_Desborde,
  output logic [3:0]  o_Blanco
);

  typedef enum logic {ACUM, ENTREGA} estado_t;

  localparam logic [7:0] CNT_CAP = 8'(ESTABLE - 2);
  localparam logic [7:0] CNT_MAX = 8'(ESTABLE);

  logic [6:0] seg_meta_reg, seg_sync_reg, seg_prev_reg;
  logic [3:0] an_meta_reg, an_sync_reg, an_prev_reg;
  logic [7:0] cnt_reg, cnt_next;
  logic       estable, captura;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      seg_meta_reg <= '1;
      seg_sync_reg <= '1;
      seg_prev_reg <= '1;
      an_meta_reg  <= '1;
      an_sync_reg  <= '1;
      an_prev_reg  <= '1;
      cnt_reg      <= '0;
    end else begin
      seg_meta_reg <= i_Segmentos;
      seg_sync_reg <= seg_meta_reg;
      seg_prev_reg <= seg_sync_reg;
      an_meta_reg  <= i_Anodos;
      an_sync_reg  <= an_meta_reg;
      an_prev_reg  <= an_sync_reg;
      cnt_reg      <= cnt_next;
    end
  end

  assign estable = ({seg_sync_reg, an_sync_reg} == {seg_prev_reg, an_prev_reg});

  always_comb begin
    cnt_next = cnt_reg;
    if (!estable)
      cnt_next = '0;
    else if (cnt_reg != CNT_MAX)
      cnt_next = cnt_reg + 8'd1;
  end

  // Fires on the single cycle the counter steps onto ESTABLE-1.
  assign captura = estable && (cnt_reg == CNT_CAP);

  logic       an_ok;
  logic [1:0] idx;

  always_comb begin
    an_ok = 1'b1;
    idx   = 2'd0;
    case (an_sync_reg)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: an_ok = 1'b0;
    endcase
  end

  logic       glifo_ok;
  logic [3:0] glifo_val;
`ifdef CAPTURA_BLANCO_EN
  logic       glifo_blanco;
`endif

  always_comb begin
    glifo_ok  = 1'b1;
    glifo_val = 4'h0;
`ifdef CAPTURA_BLANCO_EN
    glifo_blanco = 1'b0;
`endif
    case (seg_sync_reg)
      7'b0000001: glifo_val = 4'h0;
      7'b1001111: glifo_val = 4'h1;
      7'b0010010: glifo_val = 4'h2;
      7'b0000110: glifo_val = 4'h3;
      7'b1001100: glifo_val = 4'h4;
      7'b0100100: glifo_val = 4'h5;
      7'b0100000: glifo_val = 4'h6;
      7'b0001111: glifo_val = 4'h7;
      7'b0000000: glifo_val = 4'h8;
      7'b0000100: glifo_val = 4'h9;
      7'b0001000: glifo_val = 4'hA;
      7'b1100000: glifo_val = 4'hB;
      7'b0110001: glifo_val = 4'hC;
      7'b1000010: glifo_val = 4'hD;
      7'b0110000: glifo_val = 4'hE;
      7'b0111000: glifo_val = 4'hF;
`ifdef CAPTURA_BLANCO_EN
      7'b1111111: glifo_blanco = 1'b1;
`endif
      default:    glifo_ok = 1'b0;
    endcase
  end

  logic       escribir, fallo;
  logic [3:0] mask_set;

  assign escribir = captura && an_ok && glifo_ok;
  assign fallo    = captura && an_ok && !glifo_ok;
  assign mask_set = escribir ? (4'b0001 << idx) : 4'b0000;

  logic [15:0] digitos;
  logic [3:0]  blank_vec;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digito
      logic [3:0] dig_reg;
      always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n)
          dig_reg <= 4'h0;
        else if (escribir && (idx == 2'(gi)))
          dig_reg <= glifo_val;
      end
      assign digitos[gi*4 +: 4] = dig_reg;
`ifdef CAPTURA_BLANCO_EN
      logic blank_reg;
      always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n)
          blank_reg <= 1'b0;
        else if (escribir && (idx == 2'(gi)))
          blank_reg <= glifo_blanco;
      end
      assign blank_vec[gi] = blank_reg;
`else
      assign blank_vec[gi] = 1'b0;
`endif
    end
  endgenerate

  estado_t     estado_reg, estado_next;
  logic [3:0]  mask_reg, mask_next;
  logic [15:0] valor_reg, valor_next;
  logic [3:0]  blanco_reg, blanco_next;
  logic        valido_reg, valido_next;
  logic        desborde_reg, desborde_next;
  logic        error_reg;
  logic [1:0]  digito_err_reg;
  logic        limpiar;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      estado_reg     <= ACUM;
      mask_reg       <= '0;
      valor_reg      <= '0;
      blanco_reg     <= '0;
      valido_reg     <= 1'b0;
      desborde_reg   <= 1'b0;
      error_reg      <= 1'b0;
      digito_err_reg <= '0;
    end else begin
      estado_reg   <= estado_next;
      mask_reg     <= mask_next;
      valor_reg    <= valor_next;
      blanco_reg   <= blanco_next;
      valido_reg   <= valido_next;
      desborde_reg <= desborde_next;
      error_reg    <= fallo;
      if (fallo)
        digito_err_reg <= idx;
    end
  end

  always_comb begin
    estado_next   = estado_reg;
    valor_next    = valor_reg;
    blanco_next   = blanco_reg;
    valido_next   = valido_reg;
    desborde_next = desborde_reg;
    limpiar       = 1'b0;
    case (estado_reg)
      ACUM: begin
        if (mask_reg == 4'hF) begin
          valor_next  = digitos;
          blanco_next = blank_vec;
          valido_next = 1'b1;
          limpiar     = 1'b1;
          estado_next = ENTREGA;
        end
      end
      ENTREGA: begin
        // A full mask on the handshake cycle is kept and loaded from ACUM next cycle.
        if (i_Listo) begin
          valido_next = 1'b0;
          estado_next = ACUM;
        end else if (mask_reg == 4'hF) begin
          desborde_next = 1'b1;
          limpiar       = 1'b1;
        end
      end
      default: estado_next = ACUM;
    endcase
    mask_next = (limpiar ? 4'h0 : mask_reg) | mask_set;
  end

  assign o_Valor      = valor_reg;
  assign o_Valido     = valido_reg;
  assign o_Error      = error_reg;
  assign o_Digito_err = digito_err_reg;
  assign o_Desborde   = desborde_reg;
  assign o_Blanco     = blanco_reg;

endmodule

// File: tb/tb_captura_7seg_binario.sv
// Directed bench for captura_7seg_binario: scoreboard of expected frames popped on each o_Valido rise.
// Expectations for the blank digit follow CAPTURA_BLANCO_EN when the bench is built with it.
module tb_captura_7seg_binario;

  typedef struct {
    logic [15:0] valor;
    logic [3:0]  blanco;
  } frame_t;

  logic        clk;
  logic        rst_n;
  logic [6:0]  segs;
  logic [3:0]  anodos;
  logic        listo;
  logic [15:0] o_Valor;
  logic        o_Valido;
  logic        o_Error;
  logic [1:0]  o_Digito_err;
  logic        o_Desborde;
  logic [3:0]  o_Blanco;

  int total = 0;
  int bad = 0;
  int frames_seen = 0;
  int exp_frames = 0;
  int err_cnt = 0;
  int errs_ref;
  frame_t exp_q[$];

  captura_7seg_binario #(.ESTABLE(4)) dut (
    .i_Clk        (clk),
    .i_Rst_n      (rst_n),
    .i_Segmentos  (segs),
    .i_Anodos     (anodos),
    .i_Listo      (listo),
    .o_Valor      (o_Valor),
    .o_Valido     (o_Valido),
    .o_Error      (o_Error),
    .o_Digito_err (o_Digito_err),
    .o_Desborde   (o_Desborde),
    .o_Blanco     (o_Blanco)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] glifo(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b0000001;  4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;  4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;  4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;  4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;  4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;  4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;  4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;  default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // Drives raw pins at a negedge and holds them for the given number of cycles.
  task automatic drive_raw(input logic [3:0] an, input logic [6:0] seg, input int ciclos);
    anodos = an;
    segs   = seg;
    repeat (ciclos) @(negedge clk);
  endtask

  task automatic mostrar(input int k, input logic [6:0] seg, input int ciclos);
    logic [3:0] an;
    an = 4'b1111;
    an[k] = 1'b0;
    drive_raw(an, seg, ciclos);
  endtask

  task automatic frame4(input logic [15:0] v);
    mostrar(3, glifo(v[15:12]), 10);
    mostrar(2, glifo(v[11:8]), 10);
    mostrar(1, glifo(v[7:4]), 10);
    mostrar(0, glifo(v[3:0]), 10);
  endtask

  task automatic esperar(input logic [15:0] v, input logic [3:0] b);
    frame_t f;
    f.valor  = v;
    f.blanco = b;
    exp_q.push_back(f);
    exp_frames++;
  endtask

  task automatic idle(input int ciclos);
    drive_raw(4'b1111, 7'b1111111, ciclos);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valor"}, 32'(o_Valor), 32'h0);
    check({tag, "_valido"}, 32'(o_Valido), 32'h0);
    check({tag, "_error"}, 32'(o_Error), 32'h0);
    check({tag, "_digito_err"}, 32'(o_Digito_err), 32'h0);
    check({tag, "_desborde"}, 32'(o_Desborde), 32'h0);
    check({tag, "_blanco"}, 32'(o_Blanco), 32'h0);
  endtask

  // Monitor: pops the scoreboard on each o_Valido rise, checks o_Valor holds, counts o_Error cycles.
  initial begin
    logic        valido_q;
    logic [15:0] held;
    frame_t      f;
    valido_q = 1'b0;
    held     = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        valido_q = 1'b0;
      end else begin
        if (o_Valido && !valido_q) begin
          frames_seen++;
          check("frame_expected", 32'(exp_q.size() != 0), 32'h1);
          if (exp_q.size() != 0) begin
            f = exp_q.pop_front();
            check("frame_valor", 32'(o_Valor), 32'(f.valor));
            check("frame_blanco", 32'(o_Blanco), 32'(f.blanco));
          end
          held = o_Valor;
        end else if (o_Valido && valido_q) begin
          check("valor_held", 32'(o_Valor), 32'(held));
        end
        if (o_Error) err_cnt++;
        valido_q = o_Valido;
      end
    end
  end

  initial begin
    rst_n  = 1'b0;
    segs   = 7'b1111111;
    anodos = 4'b1111;
    listo  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset_init");
    @(negedge clk);
    rst_n = 1'b1;

    // Partial frame, then reset mid-stream: it must not leak into the next frame.
    listo = 1'b1;
    mostrar(3, glifo(4'h5), 10);
    mostrar(2, glifo(4'h6), 10);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    esperar(16'h1234, 4'b0000);
    frame4(16'h1234);
    idle(10);
    check("frame_1234_done", 32'(exp_q.size()), 32'h0);
    check("frames_after_1234", 32'(frames_seen), 32'(exp_frames));

    // Glitch filter: 3 cycles is too short, 6 is enough.
    mostrar(3, glifo(4'h0), 10);
    mostrar(2, glifo(4'h0), 10);
    mostrar(1, glifo(4'h0), 10);
    mostrar(0, 7'b0001000, 3);
    idle(10);
    check("glitch_no_frame", 32'(frames_seen), 32'(exp_frames));
    esperar(16'h000A, 4'b0000);
    mostrar(0, 7'b0001000, 6);
    idle(10);
    check("frame_000A_done", 32'(exp_q.size()), 32'h0);

    // Illegal glyph on digit 2.
    errs_ref = err_cnt;
    mostrar(3, glifo(4'h7), 10);
    mostrar(2, 7'b1010101, 10);
    mostrar(1, glifo(4'h8), 10);
    mostrar(0, glifo(4'h9), 10);
    idle(10);
    check("illegal_err_count", 32'(err_cnt), 32'(errs_ref + 1));
    check("illegal_digito_err", 32'(o_Digito_err), 32'h2);
    check("illegal_no_frame", 32'(frames_seen), 32'(exp_frames));
    esperar(16'h7B89, 4'b0000);
    mostrar(2, glifo(4'hB), 10);
    idle(10);
    check("frame_7B89_done", 32'(exp_q.size()), 32'h0);

    // Backpressure and overflow.
    listo = 1'b0;
    esperar(16'hFEDC, 4'b0000);
    frame4(16'hFEDC);
    idle(10);
    check("bp_valido", 32'(o_Valido), 32'h1);
    check("bp_desborde_clear", 32'(o_Desborde), 32'h0);
    frame4(16'h0000);
    idle(10);
    check("ovf_valor", 32'(o_Valor), 32'hFEDC);
    check("ovf_valido", 32'(o_Valido), 32'h1);
    check("ovf_desborde", 32'(o_Desborde), 32'h1);
    check("ovf_frames", 32'(frames_seen), 32'(exp_frames));
    listo = 1'b1;
    @(negedge clk);
    #1;
    check("handshake_valido_low", 32'(o_Valido), 32'h0);

    // Non one-hot anodes are ignored.
    errs_ref = err_cnt;
    mostrar(3, glifo(4'h1), 10);
    mostrar(2, glifo(4'h2), 10);
    mostrar(1, glifo(4'h3), 10);
    drive_raw(4'b1100, glifo(4'h5), 10);
    drive_raw(4'b1111, glifo(4'h6), 10);
    check("anodes_no_frame", 32'(frames_seen), 32'(exp_frames));
    check("anodes_no_error", 32'(err_cnt), 32'(errs_ref));
    esperar(16'h1234, 4'b0000);
    mostrar(0, glifo(4'h4), 10);
    idle(10);
    check("frame_anodes_done", 32'(exp_q.size()), 32'h0);

    // Blank pattern on digit 3.
    errs_ref = err_cnt;
`ifdef CAPTURA_BLANCO_EN
    esperar(16'h0567, 4'b1000);
    mostrar(3, 7'b1111111, 10);
    mostrar(2, glifo(4'h5), 10);
    mostrar(1, glifo(4'h6), 10);
    mostrar(0, glifo(4'h7), 10);
    idle(10);
    check("blank_no_error", 32'(err_cnt), 32'(errs_ref));
    check("blank_o_blanco", 32'(o_Blanco), 32'h8);
    check("frame_blank_done", 32'(exp_q.size()), 32'h0);
`else
    mostrar(3, 7'b1111111, 10);
    mostrar(2, glifo(4'h5), 10);
    mostrar(1, glifo(4'h6), 10);
    mostrar(0, glifo(4'h7), 10);
    idle(10);
    check("blank_err_count", 32'(err_cnt), 32'(errs_ref + 1));
    check("blank_digito_err", 32'(o_Digito_err), 32'h3);
    check("blank_no_frame", 32'(frames_seen), 32'(exp_frames));
    esperar(16'h1567, 4'b0000);
    mostrar(3, glifo(4'h1), 10);
    idle(10);
    check("frame_1567_done", 32'(exp_q.size()), 32'h0);
    check("blank_o_blanco", 32'(o_Blanco), 32'h0);
`endif

    // Reset while a frame is pending and another is partly captured.
    listo = 1'b0;
    esperar(16'h9876, 4'b0000);
    frame4(16'h9876);
    idle(10);
    check("pend_valido", 32'(o_Valido), 32'h1);
    mostrar(3, glifo(4'h1), 10);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_handshake");
    @(negedge clk);
    rst_n = 1'b1;
    listo = 1'b1;
    mostrar(2, glifo(4'h2), 10);
    mostrar(1, glifo(4'h3), 10);
    mostrar(0, glifo(4'h4), 10);
    idle(10);
    check("partial_discarded", 32'(frames_seen), 32'(exp_frames));
    esperar(16'h5234, 4'b0000);
    mostrar(3, glifo(4'h5), 10);
    idle(10);
    check("frame_5234_done", 32'(exp_q.size()), 32'h0);
    check("frames_total", 32'(frames_seen), 32'(exp_frames));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
